// File: rtl/pulse_sequencer.sv
// Laser warm-up / trigger / camera exposure frame sequencer with a shadowed timing register file.
// Optional camera channel is built only when PEWPEW_CAM_EN is defined.
module pulse_sequencer #(
    parameter int unsigned TICK_DIV = 12,
    parameter int unsigned VAL_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_addr,
    input  logic [VAL_BITS-1:0] cfg_data,
    output logic                warm,
    output logic                trig,
    output logic                cam,
    output logic                frame_start,
    output logic                busy
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW    = (VAL_BITS + 1 > 10) ? VAL_BITS + 1 : 10;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [VAL_BITS-1:0] r_period_ms, r_warm_w, r_trig_d, r_trig_w;
    logic [VAL_BITS-1:0] r_sh_period, r_sh_warm_w, r_sh_trig_d, r_sh_trig_w;
    logic                r_enable;
    logic [PRE_W-1:0]    r_pre;
    logic [9:0]          r_us;
    logic [VAL_BITS-1:0] r_ms;
    logic                r_warm, r_trig, r_cam, r_frame_start;

    logic                w_us_tick, w_frame_end, w_start, w_ms0;
    logic [VAL_BITS-1:0] w_ms_last;
    logic [VAL_BITS:0]   w_trig_end;
    logic [CW-1:0]       w_t;
    logic                w_warm, w_trig, w_cam;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_ms <= VAL_BITS'(67);
            r_warm_w    <= VAL_BITS'(10);
            r_trig_d    <= VAL_BITS'(140);
            r_trig_w    <= VAL_BITS'(10);
            r_enable    <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    r_period_ms <= cfg_data;
                3'd1:    r_warm_w    <= cfg_data;
                3'd2:    r_trig_d    <= cfg_data;
                3'd3:    r_trig_w    <= cfg_data;
                3'd6:    r_enable    <= cfg_data[0];
                default: ;
            endcase
        end
    end

    // Shadows are captured on the edge that enters a frame_start cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_period <= VAL_BITS'(67);
            r_sh_warm_w <= VAL_BITS'(10);
            r_sh_trig_d <= VAL_BITS'(140);
            r_sh_trig_w <= VAL_BITS'(10);
        end else if (w_start) begin
            r_sh_period <= r_period_ms;
            r_sh_warm_w <= r_warm_w;
            r_sh_trig_d <= r_trig_d;
            r_sh_trig_w <= r_trig_w;
        end
    end

    always_comb begin
        w_us_tick   = (r_state == S_RUN) && (r_pre == PRE_W'(TICK_DIV - 1));
        w_ms_last   = (r_sh_period == '0) ? '0 : r_sh_period - VAL_BITS'(1);
        w_frame_end = w_us_tick && (r_us == 10'd999) && (r_ms == w_ms_last);
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable) begin
                    w_state_nxt = S_RUN;
                    w_start     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_frame_end) begin
                    if (r_enable) w_start     = 1'b1;
                    else          w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || w_start || (w_state_nxt == S_IDLE)) begin
            r_pre <= '0;
            r_us  <= '0;
            r_ms  <= '0;
        end else if (w_us_tick) begin
            r_pre <= '0;
            if (r_us == 10'd999) begin
                r_us <= '0;
                r_ms <= r_ms + VAL_BITS'(1);
            end else begin
                r_us <= r_us + 10'd1;
            end
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    always_comb begin
        w_t        = CW'(r_us);
        w_ms0      = (r_state == S_RUN) && (r_ms == '0);
        w_trig_end = {1'b0, r_sh_trig_d} + {1'b0, r_sh_trig_w};
        w_warm     = w_ms0 && (w_t < CW'(r_sh_warm_w));
        w_trig     = w_ms0 && (w_t >= CW'(r_sh_trig_d)) && (w_t < CW'(w_trig_end));
    end

`ifdef PEWPEW_CAM_EN
    logic [VAL_BITS-1:0] r_cam_d, r_cam_w, r_sh_cam_d, r_sh_cam_w;
    logic [VAL_BITS:0]   w_cam_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cam_d    <= VAL_BITS'(130);
            r_cam_w    <= VAL_BITS'(30);
            r_sh_cam_d <= VAL_BITS'(130);
            r_sh_cam_w <= VAL_BITS'(30);
        end else begin
            if (cfg_we && (cfg_addr == 3'd4)) r_cam_d <= cfg_data;
            if (cfg_we && (cfg_addr == 3'd5)) r_cam_w <= cfg_data;
            if (w_start) begin
                r_sh_cam_d <= r_cam_d;
                r_sh_cam_w <= r_cam_w;
            end
        end
    end

    always_comb begin
        w_cam_end = {1'b0, r_sh_cam_d} + {1'b0, r_sh_cam_w};
        w_cam     = w_ms0 && (w_t >= CW'(r_sh_cam_d)) && (w_t < CW'(w_cam_end));
    end
`else
    assign w_cam = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm        <= 1'b0;
            r_trig        <= 1'b0;
            r_cam         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_warm        <= w_warm;
            r_trig        <= w_trig;
            r_cam         <= w_cam;
            r_frame_start <= w_start;
        end
    end

    assign warm        = r_warm;
    assign trig        = r_trig;
    assign cam         = r_cam;
    assign frame_start = r_frame_start;
    assign busy        = (r_state == S_RUN);

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed scoreboard bench for pulse_sequencer at TICK_DIV=4; cam checks follow PEWPEW_CAM_EN.
module tb_pulse_sequencer;

    localparam int SIG_WARM = 0, SIG_TRIG = 1, SIG_CAM = 2, SIG_FS = 3, SIG_BUSY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       warm, trig, cam, frame_start, busy;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string  tag;
        integer val;
    } exp_t;
    exp_t sb[$];

    pulse_sequencer #(.TICK_DIV(4), .VAL_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .warm        (warm),
        .trig        (trig),
        .cam         (cam),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic get_sig(input int id);
        case (id)
            SIG_WARM: return warm;
            SIG_TRIG: return trig;
            SIG_CAM:  return cam;
            SIG_FS:   return frame_start;
            default:  return busy;
        endcase
    endfunction

    task automatic push(input string tag, input integer val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input integer obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %0d expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Advances at least one negedge; returns the cycle where sig == lvl, or -1 on timeout.
    task automatic wait_level(input int id, input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (get_sig(id) === lvl) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic expect_rel(input string tag, input integer offs, input int id,
                              input logic lvl, input int budget, input int base);
        int at;
        push(tag, offs);
        wait_level(id, lvl, budget, at);
        check((at < 0) ? -1 : at - base);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, output int e_cyc);
        e_cyc    = cyc;
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_low(input string tag);
        push({tag, "_warm"}, 0);  check(integer'(warm));
        push({tag, "_trig"}, 0);  check(integer'(trig));
        push({tag, "_cam"}, 0);   check(integer'(cam));
        push({tag, "_fs"}, 0);    check(integer'(frame_start));
        push({tag, "_busy"}, 0);  check(integer'(busy));
    endtask

    initial begin
        int e, f, f2, at, n_warm, n_trig, n_cam;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_low("rst");

        // 1: defaults, only enable written
        wr(3'd6, 8'd1, e);
        expect_rel("t1_fs_latency", 2, SIG_FS, 1'b1, 10, e);
        f = cyc;
        @(negedge clk);
        push("t1_fs_width", 0); check(integer'(frame_start));
        push("t1_warm_at_f1", 1); check(integer'(warm));
        expect_rel("t1_warm_fall", 41, SIG_WARM, 1'b0, 100, f);
`ifdef PEWPEW_CAM_EN
        expect_rel("t1_cam_rise", 521, SIG_CAM, 1'b1, 1000, f);
`endif
        expect_rel("t1_trig_rise", 561, SIG_TRIG, 1'b1, 1000, f);
        expect_rel("t1_trig_fall", 601, SIG_TRIG, 1'b0, 1000, f);
`ifdef PEWPEW_CAM_EN
        expect_rel("t1_cam_fall", 641, SIG_CAM, 1'b0, 1000, f);
`endif

        // 5: reset mid-frame while cam is high
        do_reset();
        wr(3'd0, 8'd5, e);
        wr(3'd6, 8'd1, e);
        expect_rel("t5_fs_latency", 2, SIG_FS, 1'b1, 10, e);
        f = cyc;
        while (cyc < f + 530) @(negedge clk);
`ifdef PEWPEW_CAM_EN
        push("t5_cam_before_rst", 1); check(integer'(cam));
`endif
        push("t5_busy_before_rst", 1); check(integer'(busy));
        do_reset();
        check_all_low("t5_after_rst");
        push("t5_period_readback", 67); check(integer'(dut.r_period_ms));

        // 2: period_ms = 0 behaves as a 1 ms frame
        do_reset();
        wr(3'd0, 8'd0, e);
        wr(3'd6, 8'd1, e);
        expect_rel("t2_fs_latency", 2, SIG_FS, 1'b1, 10, e);
        f = cyc;
        expect_rel("t2_frame_len_a", 4000, SIG_FS, 1'b1, 5000, f);
        f = cyc;
        expect_rel("t2_frame_len_b", 4000, SIG_FS, 1'b1, 5000, f);

        // 3: mid-frame trig_d write only affects the next frame
        do_reset();
        wr(3'd0, 8'd1, e);
        wr(3'd6, 8'd1, e);
        wait_level(SIG_FS, 1'b1, 10, at);
        f = at;
        while (cyc < f + 100) @(negedge clk);
        wr(3'd2, 8'd20, e);
        expect_rel("t3_trig_cur_frame", 561, SIG_TRIG, 1'b1, 1000, f);
        expect_rel("t3_frame_len", 4000, SIG_FS, 1'b1, 5000, f);
        f2 = cyc;
        expect_rel("t3_trig_next_frame", 81, SIG_TRIG, 1'b1, 1000, f2);

        // 4: clearing enable finishes the running frame then idles
        do_reset();
        wr(3'd0, 8'd1, e);
        wr(3'd6, 8'd1, e);
        wait_level(SIG_FS, 1'b1, 10, at);
        f = at;
        while (cyc < f + 1000) @(negedge clk);
        wr(3'd6, 8'd0, e);
        while (cyc < f + 3999) @(negedge clk);
        push("t4_busy_last_cycle", 1); check(integer'(busy));
        expect_rel("t4_busy_drop", 4000, SIG_BUSY, 1'b0, 5000, f);
        expect_rel("t4_no_more_fs", -1, SIG_FS, 1'b1, 5000, f);

        // 6: zero widths suppress warm and trig for a whole frame
        do_reset();
        wr(3'd0, 8'd1, e);
        wr(3'd1, 8'd0, e);
        wr(3'd3, 8'd0, e);
        wr(3'd6, 8'd1, e);
        wait_level(SIG_FS, 1'b1, 10, at);
        n_warm = 0; n_trig = 0; n_cam = 0;
        for (int i = 0; i < 3999; i++) begin
            @(negedge clk);
            n_warm += int'(warm === 1'b1);
            n_trig += int'(trig === 1'b1);
            n_cam  += int'(cam === 1'b1);
        end
        push("t6_warm_cycles", 0); check(n_warm);
        push("t6_trig_cycles", 0); check(n_trig);
`ifdef PEWPEW_CAM_EN
        push("t6_cam_cycles", 120); check(n_cam);
`else
        push("t6_cam_cycles", 0); check(n_cam);
`endif

        push("sb_drained", 0); check(integer'(sb.size()) - 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
